// File: rtl/btb.sv
// Two-way set-associative branch target buffer: combinational IF lookup,
// lookup package carried IF->ID->EX, resolved-branch update in EX.
module btb #(
  parameter int unsigned s_idx       = 4,
  parameter int unsigned s_pc_offset = 2,
  parameter int unsigned s_tag       = 32 - s_idx - s_pc_offset
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        stall_ex,
  input  logic [31:0] addr,
  output logic        btb_hit,
  output logic [31:0] btb_target,
  input  logic        update,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        target_mispred
);

  localparam int unsigned sets = 2 ** s_idx;

  typedef struct packed {
    logic [s_idx-1:0]  idx;
    logic [s_tag-1:0]  tag;
    logic              hit;
    logic              way;
    logic [31:0]       target;
  } pkg_t;

  logic [1:0][sets-1:0] valid;
  logic [sets-1:0]      lru;
  logic [s_tag-1:0]     tag_mem [2][sets];
  logic [31:0]          tgt_mem [2][sets];

  pkg_t             pkg_if, pkg_id, pkg_ex;
  logic [s_idx-1:0] idx_if;
  logic [s_tag-1:0] tag_if;
  logic             hit0, hit1;
  logic             victim, wr_way, wr_en;

  assign idx_if = addr[s_idx+s_pc_offset-1:s_pc_offset];
  assign tag_if = addr[31:s_idx+s_pc_offset];

  // Way 0 takes priority if both ways match the tag.
  always_comb begin
    hit0          = valid[0][idx_if] && (tag_mem[0][idx_if] == tag_if);
    hit1          = valid[1][idx_if] && (tag_mem[1][idx_if] == tag_if);
    pkg_if.idx    = idx_if;
    pkg_if.tag    = tag_if;
    pkg_if.hit    = hit0 | hit1;
    pkg_if.way    = ~hit0 & hit1;
    pkg_if.target = hit0 ? tgt_mem[0][idx_if] : (hit1 ? tgt_mem[1][idx_if] : '0);
  end

  assign btb_hit    = pkg_if.hit;
  assign btb_target = pkg_if.target;

  // Victim: first invalid way, otherwise the set's LRU way.
  always_comb begin
    if (!valid[0][pkg_ex.idx])      victim = 1'b0;
    else if (!valid[1][pkg_ex.idx]) victim = 1'b1;
    else                            victim = lru[pkg_ex.idx];
  end

  assign wr_way = pkg_ex.hit ? pkg_ex.way : victim;
  assign wr_en  = update & br_en & ~rst;

  assign target_mispred = update & br_en & (~pkg_ex.hit | (pkg_ex.target != br_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      lru    <= '0;
      pkg_id <= '0;
      pkg_ex <= '0;
    end else begin
      if (!stall_id) pkg_id <= pkg_if;
      if (!stall_ex) pkg_ex <= pkg_id;
      if (wr_en) begin
        lru[pkg_ex.idx] <= ~wr_way;
        if (!pkg_ex.hit) valid[victim][pkg_ex.idx] <= 1'b1;
      end
    end
  end

  // Tag/target storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tgt_mem[wr_way][pkg_ex.idx] <= br_target;
      if (!pkg_ex.hit) tag_mem[wr_way][pkg_ex.idx] <= pkg_ex.tag;
    end
  end

endmodule

// File: tb/tb_btb.sv
// Scoreboard bench for btb: expectations queued at stimulus time, popped
// and compared when the DUT output for that stimulus is observable.
module tb_btb;

  localparam logic [31:0] FILL = 32'hFFF0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        stall_ex = 1'b0;
  logic [31:0] addr = '0;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        update = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = '0;
  logic        target_mispred;

  int total = 0;
  int bad   = 0;

  logic [32:0] look_q [$];
  logic        misp_q [$];

  always #5 clk = ~clk;

  btb #(.s_idx(4), .s_pc_offset(2)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
    .addr(addr), .btb_hit(btb_hit), .btb_target(btb_target),
    .update(update), .br_en(br_en), .br_target(br_target),
    .target_mispred(target_mispred)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a branch through IF and ID; returns with the EX-cycle update driven.
  task automatic resolve(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic exp_m);
    addr = pc;
    step();
    addr = FILL;
    step();
    update    = 1'b1;
    br_en     = taken;
    br_target = tgt;
    misp_q.push_back(exp_m);
  endtask

  task automatic test_reset();
    logic [32:0] e;
    rst = 1'b1; update = 1'b0; br_en = 1'b1; br_target = 32'h5; addr = 32'h60;
    step(); step();
    rst = 1'b0;
    look_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    e = look_q.pop_front();
    total++;
    if ({btb_hit, btb_target} !== e) begin
      bad++; $display("FAIL reset_lookup: got %h want %h", {btb_hit, btb_target}, e);
    end
    total++;
    if (target_mispred !== 1'b0) begin
      bad++; $display("FAIL reset_mispred_no_update: got %b want 0", target_mispred);
    end
    step();
    br_en = 1'b0; br_target = '0;
  endtask

  task automatic test_allocate_and_retarget();
    logic [31:0] pcs  [3] = '{32'h60, 32'h60, 32'h60};
    logic [31:0] tgts [3] = '{32'h100, 32'h100, 32'h140};
    logic        exps [3] = '{1'b1, 1'b0, 1'b1};
    logic [32:0] want [3] = '{{1'b1, 32'h100}, {1'b1, 32'h100}, {1'b1, 32'h140}};
    logic e;
    logic [32:0] el;
    for (int i = 0; i < 3; i++) begin
      resolve(pcs[i], 1'b1, tgts[i], exps[i]);
      @(negedge clk);
      e = misp_q.pop_front();
      total++;
      if (target_mispred !== e) begin
        bad++; $display("FAIL retarget_mispred[%0d]: got %b want %b", i, target_mispred, e);
      end
      step();
      update = 1'b0; br_en = 1'b0;
      addr = pcs[i];
      look_q.push_back(want[i]);
      @(negedge clk);
      el = look_q.pop_front();
      total++;
      if ({btb_hit, btb_target} !== el) begin
        bad++; $display("FAIL retarget_lookup[%0d]: got %h want %h", i, {btb_hit, btb_target}, el);
      end
      step();
    end
  endtask

  task automatic test_conflict();
    logic [31:0] pcs  [4] = '{32'h40, 32'h80, 32'h40, 32'hC0};
    logic [31:0] tgts [4] = '{32'h400, 32'h800, 32'h400, 32'hC00};
    logic        exps [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] lpc  [3] = '{32'h40, 32'h80, 32'hC0};
    logic [32:0] want [3] = '{{1'b1, 32'h400}, {1'b0, 32'h0}, {1'b1, 32'hC00}};
    logic e;
    logic [32:0] el;
    for (int i = 0; i < 4; i++) begin
      resolve(pcs[i], 1'b1, tgts[i], exps[i]);
      @(negedge clk);
      e = misp_q.pop_front();
      total++;
      if (target_mispred !== e) begin
        bad++; $display("FAIL conflict_mispred[%0d]: got %b want %b", i, target_mispred, e);
      end
      step();
      update = 1'b0; br_en = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      addr = lpc[i];
      look_q.push_back(want[i]);
      @(negedge clk);
      el = look_q.pop_front();
      total++;
      if ({btb_hit, btb_target} !== el) begin
        bad++; $display("FAIL conflict_lookup[%0d]: got %h want %h", i, {btb_hit, btb_target}, el);
      end
      step();
    end
  endtask

  task automatic test_not_taken();
    logic e;
    logic [32:0] el;
    resolve(32'h200, 1'b0, 32'h300, 1'b0);
    @(negedge clk);
    e = misp_q.pop_front();
    total++;
    if (target_mispred !== e) begin
      bad++; $display("FAIL not_taken_mispred: got %b want %b", target_mispred, e);
    end
    step();
    update = 1'b0; br_en = 1'b0;
    addr = 32'h200;
    look_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    el = look_q.pop_front();
    total++;
    if ({btb_hit, btb_target} !== el) begin
      bad++; $display("FAIL not_taken_lookup: got %h want %h", {btb_hit, btb_target}, el);
    end
    step();
  endtask

  // 0x60 holds 0x140 in set 8; it must stay in EX while 0x80 (a miss) waits in ID.
  task automatic test_stall();
    logic [31:0] spc [3] = '{32'h40, 32'hC0, 32'h100};
    logic e;
    logic [32:0] el;
    addr = 32'h60;
    step();
    addr = 32'h80;
    step();
    stall_id = 1'b1; stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = spc[i];
      step();
    end
    stall_id = 1'b0; stall_ex = 1'b0;
    update = 1'b1; br_en = 1'b1; br_target = 32'h140;
    misp_q.push_back(1'b0);
    @(negedge clk);
    e = misp_q.pop_front();
    total++;
    if (target_mispred !== e) begin
      bad++; $display("FAIL stall_held_pkg: got %b want %b", target_mispred, e);
    end
    step();
    update = 1'b0; br_en = 1'b0;
    addr = 32'h80;
    look_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    el = look_q.pop_front();
    total++;
    if ({btb_hit, btb_target} !== el) begin
      bad++; $display("FAIL stall_no_alloc: got %h want %h", {btb_hit, btb_target}, el);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs  [5] = '{32'h40, 32'h60, 32'hC0, 32'h80, 32'h440};
    logic [32:0] want [5] = '{{1'b1, 32'h400}, {1'b1, 32'h140}, {1'b1, 32'hC00},
                              {1'b0, 32'h0}, {1'b0, 32'h0}};
    logic [32:0] el;
    for (int i = 0; i < 5; i++) begin
      addr = pcs[i];
      look_q.push_back(want[i]);
      @(negedge clk);
      el = look_q.pop_front();
      total++;
      if ({btb_hit, btb_target} !== el) begin
        bad++; $display("FAIL b2b_lookup[%0d]: got %h want %h", i, {btb_hit, btb_target}, el);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_update();
    logic [31:0] pcs [4] = '{32'h300, 32'h40, 32'h60, 32'hC0};
    logic e;
    logic [32:0] el;
    resolve(32'h300, 1'b1, 32'h500, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    e = misp_q.pop_front();
    total++;
    if (target_mispred !== e) begin
      bad++; $display("FAIL rst_cycle_mispred: got %b want %b", target_mispred, e);
    end
    step();
    rst = 1'b0; update = 1'b0; br_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = pcs[i];
      look_q.push_back({1'b0, 32'h0});
      @(negedge clk);
      el = look_q.pop_front();
      total++;
      if ({btb_hit, btb_target, target_mispred} !== {el, 1'b0}) begin
        bad++; $display("FAIL post_rst_lookup[%0d]: got %h want %h", i,
                        {btb_hit, btb_target, target_mispred}, {el, 1'b0});
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_allocate_and_retarget();
    test_conflict();
    test_not_taken();
    test_stall();
    test_back_to_back();
    test_reset_mid_update();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb.md
# btb

Branch target buffer for the RV32I pipeline's fetch stage. It sits beside the global-history direction predictor. In IF it looks up the fetch PC and supplies a predicted target, which the next-PC mux uses whenever the direction predictor says taken. The lookup result travels IF→ID→EX with the same stall rules as the predictor. In EX the resolved branch outcome updates the table and flags target mispredictions.

## Interface
Parameters:
- s_idx, 4: set-index bits; sets = 2**s_idx.
- s_pc_offset, 2: PC bits below the index; index = addr[s_idx+s_pc_offset-1:s_pc_offset].
- s_tag, 32-s_idx-s_pc_offset: tag width; tag = addr[31:s_idx+s_pc_offset].

Ports (clock and reset: one clock, `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_id  in  1  hold the ID-stage lookup package.
- stall_ex  in  1  hold the EX-stage lookup package.
- addr  in  32  IF fetch PC.
- btb_hit  out  1  IF: valid entry with matching tag found.
- btb_target  out  32  IF: stored target of the hitting way; 0 on miss.
- update  in  1  EX holds a resolved branch or jump this cycle.
- br_en  in  1  EX: branch actually taken.
- br_target  in  32  EX: actual target address.
- target_mispred  out  1  EX: update & br_en & (!hit_ex | stored target ≠ br_target).

## Operation
- Storage: 2 ways × 2**s_idx sets. Each entry holds valid, tag[s_tag] and target[32]. Each set has one LRU bit naming the way to replace next.
- IF lookup (combinational):
  - Both ways of set addr-index are compared against the addr tag.
  - A hit requires valid and a tag match. If both ways match, way 0 wins.
  - btb_hit/btb_target come from the hitting way; btb_target = 0 on miss.
- Lookup package {idx, tag, hit, way, target} is formed in IF.
  - pkg_id <= stall_id ? pkg_id : pkg_if.
  - pkg_ex <= stall_ex ? pkg_ex : pkg_id.
  - EX uses only pkg_ex. It never re-reads the arrays.
- EX update, when update=1:
  - br_en=1 and pkg_ex.hit: overwrite the target of pkg_ex.way with br_target; LRU[idx] <= ~way.
  - br_en=1 and miss: allocate a victim way (an invalid way first, way 0 before way 1; else way LRU[idx]). Write valid=1, the tag and br_target. LRU[idx] <= ~victim.
  - br_en=0: no array change. A not-taken hit also leaves LRU unchanged.
- target_mispred is combinational in EX and is 0 whenever update=0.
- The predictor redirects only when btb_hit & br_take. It sizes penalties from its own mispred OR target_mispred.

## Timing
- Lookup: zero-latency combinational from addr to btb_hit/btb_target.
- Update: arrays and LRU are written at the posedge ending the update cycle. The result is visible to IF lookups from the next cycle.
- Same-cycle IF lookup and EX update to the same set: IF sees pre-update contents. There is no bypass.
- Stalls:
  - A stalled stage holds its package indefinitely.
  - With stall_id=1 and stall_ex=0, pkg_ex reloads pkg_id each cycle; the duplicate is harmless because update is gated by EX.
  - update while stall_ex=1 is the pipeline's responsibility; the block still acts on every update cycle.
- Reset, applied on any cycle including mid-update:
  - All valid bits and LRU bits clear, and both packages clear, at the next posedge.
  - The reset cycle's update is discarded.
  - After reset: btb_hit=0, btb_target=0, target_mispred=0.
- Index wrap: PCs differing only above the index alias to the same set and are separated by tag.

## Test plan
- Reset, then lookup addr=0x60 → btb_hit=0, btb_target=0. Update for a taken branch at 0x60 to 0x100 → target_mispred=1 in the EX cycle; a lookup of 0x60 on the next cycle gives hit=1, target=0x100.
- Re-resolve the branch at 0x60 as taken to 0x100 → target_mispred=0. Resolve it taken to 0x140 → target_mispred=1, and the stored target becomes 0x140.
- Conflict: s_idx=4, offset=2; taken branches at 0x40, 0x80 and 0xC0 all map to set 0.
  - 0x40 fills way 0 and 0x80 fills way 1.
  - A hit on 0x40 makes way 1 the LRU, so 0xC0 evicts 0x80.
  - Result: 0x40 hits, 0x80 misses, 0xC0 hits.
- Not-taken resolve of an absent branch at 0x200 → no allocation, target_mispred=0; a later lookup of 0x200 misses.
- Stall: hold stall_ex=1 for 3 cycles while addr changes → pkg_ex is unchanged. After release, the EX update uses the held idx/way.
- Assert rst in the same cycle as update=1 with br_en=1 → after reset all lookups miss, and the update is not applied.
